// File: rtl/rvvi_retire_serializer.sv
// Serializes per-cycle multi-hart retirement batches into a single record stream.
// Latency: a batch enqueued into an empty queue shows its first record one cycle later.
// Backpressure: out_ready stalls records in a DEPTH-batch FIFO; a full FIFO with no pop drops the batch.
module rvvi_retire_serializer #(
   parameter int NHART  = 1,
   parameter int RETIRE = 1,
   parameter int ILEN   = 32,
   parameter int DEPTH  = 4,
   localparam int HW    = (NHART  > 1) ? $clog2(NHART)  : 1,
   localparam int SW    = (RETIRE > 1) ? $clog2(RETIRE) : 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NHART*RETIRE-1:0]      in_valid,
   input  logic [NHART*RETIRE*ILEN-1:0] in_insn,
   input  logic [NHART*RETIRE-1:0]      in_trap,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [HW-1:0]                out_hart,
   output logic [SW-1:0]                out_slot,
   output logic [ILEN-1:0]              out_insn,
   output logic                         out_trap,
   output logic [31:0]                  out_seq,
   output logic                         overflow,
   output logic [15:0]                  drop_count,
   input  logic                         clr_overflow
);

   localparam int NS = NHART * RETIRE;
   localparam int KW = (NS > 1) ? $clog2(NS) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // Batch storage; the head entry stays in place while its records drain
   logic [NS-1:0]      r_mem_vld  [DEPTH];
   logic [NS*ILEN-1:0] r_mem_insn [DEPTH];
   logic [NS-1:0]      r_mem_trap [DEPTH];

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   state_t        r_state;
   logic [NS-1:0] r_rem;       // head-batch slots not yet accepted, current record included
   logic          r_out_valid;
   logic [HW-1:0] r_out_hart;
   logic [SW-1:0] r_out_slot;
   logic [ILEN-1:0] r_out_insn;
   logic          r_out_trap;
   logic [31:0]   r_seq;
   logic          r_ovf;
   logic [15:0]   r_drop_cnt;

   logic          w_accept;
   logic [NS-1:0] w_rem_after;
   logic          w_batch_done;
   logic          w_full;
   logic          w_any_in;
   logic          w_push;
   logic          w_drop;
   logic [CW-1:0] w_count_nxt;
   logic [CW-1:0] w_base;
   logic [AW-1:0] w_rd_nxt;
   logic          w_bypass;
   logic          w_reload;
   logic [NS-1:0]      w_src_vld;
   logic [NS*ILEN-1:0] w_src_insn;
   logic [NS-1:0]      w_src_trap;
   logic [NS-1:0] w_rem_nxt;
   logic [KW-1:0] w_k;
   logic [HW-1:0] w_nxt_hart;
   logic [SW-1:0] w_nxt_slot;
   logic [ILEN-1:0] w_nxt_insn;
   logic          w_nxt_trap;

   // Handshake, FIFO push/pop/drop decisions and the next head-batch source
   always_comb begin
      w_accept     = r_out_valid && out_ready;
      w_rem_after  = w_accept ? (r_rem & (r_rem - NS'(1))) : r_rem;
      w_batch_done = w_accept && (w_rem_after == '0);
      w_full       = (r_count == CW'(DEPTH));
      w_any_in     = |in_valid;
      // A full FIFO still takes the new batch when the head batch leaves this cycle
      w_push       = w_any_in && (!w_full || w_batch_done);
      w_drop       = w_any_in && !w_push;
      w_count_nxt  = r_count + CW'(w_push) - CW'(w_batch_done);
      w_base       = r_count - CW'(w_batch_done);
      w_rd_nxt     = r_rd_ptr + AW'(w_batch_done);
      // With nothing left stored, the next head is the batch arriving right now
      w_bypass     = (w_base == '0);
      w_reload     = w_batch_done || (r_count == '0);
      w_src_vld    = w_bypass ? in_valid : r_mem_vld[w_rd_nxt];
      w_src_insn   = w_bypass ? in_insn  : r_mem_insn[w_rd_nxt];
      w_src_trap   = w_bypass ? in_trap  : r_mem_trap[w_rd_nxt];
      w_rem_nxt    = w_reload ? w_src_vld : w_rem_after;
   end

   // Lowest pending slot of the next head gives the next record (hart-major order)
   always_comb begin
      w_k = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (w_rem_nxt[i]) begin
            w_k = KW'(i);
         end
      end
      w_nxt_hart = HW'(32'(w_k) / RETIRE);
      w_nxt_slot = SW'(32'(w_k) % RETIRE);
      w_nxt_insn = w_src_insn[w_k*ILEN +: ILEN];
      w_nxt_trap = w_src_trap[w_k];
   end

   // Batch storage write; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (reset_n && w_push) begin
         r_mem_vld[r_wr_ptr]  <= in_valid;
         r_mem_insn[r_wr_ptr] <= in_insn;
         r_mem_trap[r_wr_ptr] <= in_trap;
      end
   end

   // FIFO pointers and batch occupancy
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push);
         r_rd_ptr <= w_rd_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Drain FSM with registered record outputs, sequence counter and drop tracking
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_EMPTY;
         r_rem       <= '0;
         r_out_valid <= 1'b0;
         r_out_hart  <= '0;
         r_out_slot  <= '0;
         r_out_insn  <= '0;
         r_out_trap  <= 1'b0;
         r_seq       <= '0;
         r_ovf       <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         r_rem <= w_rem_nxt;
         if (w_accept) begin
            r_seq <= r_seq + 32'd1;
         end
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  r_state     <= ST_DRAIN;
                  r_out_valid <= 1'b1;
                  r_out_hart  <= w_nxt_hart;
                  r_out_slot  <= w_nxt_slot;
                  r_out_insn  <= w_nxt_insn;
                  r_out_trap  <= w_nxt_trap;
               end
            end
            ST_DRAIN: begin
               if (w_count_nxt == '0) begin
                  r_state     <= ST_EMPTY;
                  r_out_valid <= 1'b0;
               end else if (w_accept) begin
                  // Fields only move on acceptance, so they hold while stalled
                  r_out_valid <= 1'b1;
                  r_out_hart  <= w_nxt_hart;
                  r_out_slot  <= w_nxt_slot;
                  r_out_insn  <= w_nxt_insn;
                  r_out_trap  <= w_nxt_trap;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
            end
         endcase
         // A drop in the same cycle as a clear wins, leaving a fresh count of one
         if (clr_overflow) begin
            r_ovf      <= w_drop;
            r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
         end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
               r_drop_cnt <= r_drop_cnt + 16'd1;
            end
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_hart   = r_out_hart;
   assign out_slot   = r_out_slot;
   assign out_insn   = r_out_insn;
   assign out_trap   = r_out_trap;
   assign out_seq    = r_seq;
   assign overflow   = r_ovf;
   assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// Bench for the retirement serializer: NHART=2, RETIRE=2, DEPTH=4.
// Reference model keeps a flat queue of expected records plus a stored-batch count.
// Directed scenarios first, then a randomized run with the same per-cycle checks.
module tb_rvvi_retire_serializer;

   localparam int NH = 2;
   localparam int RT = 2;
   localparam int IL = 32;
   localparam int DP = 4;
   localparam int NS = NH * RT;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NS-1:0]     in_valid;
   logic [NS*IL-1:0]  in_insn;
   logic [NS-1:0]     in_trap;
   logic              out_valid;
   logic              out_ready;
   logic [0:0]        out_hart;
   logic [0:0]        out_slot;
   logic [IL-1:0]     out_insn;
   logic              out_trap;
   logic [31:0]       out_seq;
   logic              overflow;
   logic [15:0]       drop_count;
   logic              clr_overflow;

   always #5 clk = ~clk;

   rvvi_retire_serializer #(.NHART(NH), .RETIRE(RT), .ILEN(IL), .DEPTH(DP)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_insn(in_insn), .in_trap(in_trap),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hart(out_hart), .out_slot(out_slot), .out_insn(out_insn), .out_trap(out_trap),
      .out_seq(out_seq), .overflow(overflow), .drop_count(drop_count),
      .clr_overflow(clr_overflow)
   );

   typedef struct {
      int          hart;
      int          slot;
      logic [31:0] insn;
      logic        trap;
      bit          last;
   } rec_t;

   rec_t        rq[$];
   int          nb;
   int unsigned mseq;
   bit          movf;
   int          mdc;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Apply one clock edge to the model using the inputs currently driven
   task automatic model_edge();
      bit   drop;
      rec_t r;
      int   lastk;
      if (!reset_n) begin
         rq.delete();
         nb = 0; mseq = 0; movf = 0; mdc = 0;
         return;
      end
      if (rq.size() > 0 && out_ready) begin
         r = rq.pop_front();
         if (r.last) nb--;
         mseq++;
      end
      drop = 0;
      if (in_valid != '0) begin
         if (nb < DP) begin
            lastk = -1;
            for (int k = 0; k < NS; k++) if (in_valid[k]) lastk = k;
            for (int h = 0; h < NH; h++) begin
               for (int s = 0; s < RT; s++) begin
                  if (in_valid[h*RT+s]) begin
                     r.hart = h;
                     r.slot = s;
                     r.insn = in_insn[(h*RT+s)*IL +: IL];
                     r.trap = in_trap[h*RT+s];
                     r.last = ((h*RT+s) == lastk);
                     rq.push_back(r);
                  end
               end
            end
            nb++;
         end else begin
            drop = 1;
         end
      end
      if (clr_overflow) begin
         movf = drop;
         mdc  = drop ? 1 : 0;
      end else if (drop) begin
         movf = 1;
         if (mdc < 65535) mdc++;
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(rq.size() > 0));
      if (rq.size() > 0) begin
         chk("out_hart", 32'(out_hart), 32'(rq[0].hart));
         chk("out_slot", 32'(out_slot), 32'(rq[0].slot));
         chk("out_insn", out_insn, rq[0].insn);
         chk("out_trap", 32'(out_trap), 32'(rq[0].trap));
         chk("out_seq", out_seq, mseq);
      end
      chk("overflow", 32'(overflow), 32'(movf));
      chk("drop_count", 32'(drop_count), 32'(mdc));
   endtask

   task automatic cyc(input logic [NS-1:0] v, input logic rdy, input logic clr, input logic rst);
      in_valid = v;
      for (int k = 0; k < NS; k++) in_insn[k*IL +: IL] = $urandom;
      in_trap      = NS'($urandom);
      out_ready    = rdy;
      clr_overflow = clr;
      reset_n      = rst;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic check_reset_fields();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_seq", out_seq, 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
      chk("rst_out_hart", 32'(out_hart), 32'd0);
      chk("rst_out_slot", 32'(out_slot), 32'd0);
      chk("rst_out_insn", out_insn, 32'd0);
      chk("rst_out_trap", 32'(out_trap), 32'd0);
   endtask

   initial begin
      logic [NS-1:0] v;
      nb = 0; mseq = 0; movf = 0; mdc = 0;

      // Reset, with in_valid asserted to show nothing is captured during reset
      cyc(4'b1111, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0, 1'b0);
      check_reset_fields();

      // Single 1011 batch serializes as (h0,s0),(h0,s1),(h1,s1), seq 0..2
      cyc(4'b1011, 1'b1, 1'b0, 1'b1);
      chk("first_rec_valid", 32'(out_valid), 32'd1);
      chk("first_rec_seq", out_seq, 32'd0);
      for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b1);
      chk("seq_after_three", out_seq, 32'd3);

      // Five batches into a stalled 4-deep FIFO: one dropped, then drain the four
      for (int i = 0; i < 5; i++) cyc(4'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b1);
      chk("ovf_after_five", 32'(overflow), 32'd1);
      chk("dc_after_five", 32'(drop_count), 32'd1);
      for (int i = 0; i < 20; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b1);

      // Clear, fill with single-record batches, then pop head and push together
      cyc(4'b0000, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cyc(4'b0001 << i, 1'b0, 1'b0, 1'b1);
      cyc(4'b0110, 1'b1, 1'b0, 1'b1);
      chk("no_drop_on_pop", 32'(drop_count), 32'd0);
      for (int i = 0; i < 8; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b1);

      // Toggling out_ready over a three-record batch
      cyc(4'b1101, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cyc(4'b0000, 1'(i % 2), 1'b0, 1'b1);

      // Accumulate five drops, then a drop coincident with clear
      for (int i = 0; i < 9; i++) cyc(4'b1111, 1'b0, 1'b0, 1'b1);
      chk("dc_five", 32'(drop_count), 32'd5);
      cyc(4'b1010, 1'b0, 1'b1, 1'b1);
      chk("dc_clr_with_drop", 32'(drop_count), 32'd1);
      chk("ovf_clr_with_drop", 32'(overflow), 32'd1);

      // One-cycle reset with batches pending
      cyc(4'b0000, 1'b1, 1'b0, 1'b0);
      check_reset_fields();
      cyc(4'b0000, 1'b1, 1'b0, 1'b1);
      chk("post_reset_empty", 32'(out_valid), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         v = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
         cyc(v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
             1'($urandom_range(0, 200) != 0));
      end
      for (int i = 0; i < 24; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b1);
      chk("final_empty", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
